// File: rtl/keypad_entry.sv
// 4x4 hex keypad scanner: walks a low on the columns, debounces whole-scan results and shifts
// accepted digits into a right-aligned 32-bit value with a matching digit-blanking mask.
module keypad_entry #(
  parameter int unsigned SCAN_DIV       = 62499,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  input  logic        clear,
  output logic [3:0]  col,
  output logic [31:0] number,
  output logic [7:0]  AN_ON,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  localparam int unsigned PrescW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(SCAN_DIV);
  localparam logic [3:0] DebN = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StIdle, StDebounce, StHeld} state_e;

  logic [3:0]        row_meta_q, row_meta_d, row_sync_q, row_sync_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [1:0]        col_idx_q, col_idx_d;
  // Keys seen so far this scan, saturating at 2 (= MULTI)
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [3:0]        acc_code_q, acc_code_d;
  state_e            state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        rel_q, rel_d;
  logic [31:0]       number_q, number_d;
  logic [7:0]        an_q, an_d;
  logic              key_valid_q, key_valid_d;
  logic [3:0]        key_code_q, key_code_d;

  logic       tick, scan_done, accept;
  logic [1:0] samp_cnt, tot_cnt;
  logic [3:0] samp_code, tot_code;
  logic [2:0] sum;

  function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    unique case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'h0;
      4'b11_01: k = 4'hF;
      4'b11_10: k = 4'hE;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  // Decode the rows sampled for the driven column and merge them into this scan's result
  always_comb begin
    samp_cnt  = 2'd0;
    samp_code = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_q[r]) begin
        samp_cnt  = (samp_cnt == 2'd2) ? 2'd2 : samp_cnt + 2'd1;
        samp_code = key_lut(2'(r), col_idx_q);
      end
    end
    sum      = {1'b0, acc_cnt_q} + {1'b0, samp_cnt};
    tot_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    tot_code = (samp_cnt != 2'd0) ? samp_code : acc_code_q;
  end

  // Prescaler, column walk and per-scan accumulation
  always_comb begin
    row_meta_d = row;
    row_sync_d = row_meta_q;
    tick       = (presc_q == PrescMax);
    presc_d    = tick ? '0 : presc_q + 1'b1;
    col_idx_d  = col_idx_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    scan_done  = 1'b0;
    if (tick) begin
      col_idx_d = col_idx_q + 2'd1;
      if (col_idx_q == 2'd3) begin
        scan_done  = 1'b1;
        acc_cnt_d  = 2'd0;
        acc_code_d = 4'd0;
      end else begin
        acc_cnt_d  = tot_cnt;
        acc_code_d = tot_code;
      end
    end
  end

  // Debounce FSM: advances once per full scan
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    accept  = 1'b0;
    if (scan_done) begin
      unique case (state_q)
        StIdle: begin
          if (tot_cnt == 2'd1) begin
            cand_d = tot_code;
            cnt_d  = 4'd1;
            if (DebN == 4'd1) begin
              accept  = 1'b1;
              state_d = StHeld;
              rel_d   = 4'd0;
            end else begin
              state_d = StDebounce;
            end
          end
        end
        StDebounce: begin
          if (tot_cnt == 2'd1 && tot_code == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == DebN) begin
              accept  = 1'b1;
              state_d = StHeld;
              rel_d   = 4'd0;
            end
          end else begin
            state_d = StIdle;
            cnt_d   = 4'd0;
          end
        end
        StHeld: begin
          if (tot_cnt == 2'd0) begin
            rel_d = rel_q + 4'd1;
            if (rel_d == DebN) begin
              state_d = StIdle;
              rel_d   = 4'd0;
            end
          end else begin
            rel_d = 4'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Digit entry; clear overrides a coincident accept for the value and mask only
  always_comb begin
    key_valid_d = accept;
    key_code_d  = accept ? cand_d : key_code_q;
    number_d    = number_q;
    an_d        = an_q;
    if (clear) begin
      number_d = 32'd0;
      an_d     = 8'hFF;
    end else if (accept) begin
      number_d = {number_q[27:0], cand_d};
      an_d     = {an_q[6:0], 1'b0};
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      presc_q     <= '0;
      col_idx_q   <= 2'd0;
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= 4'd0;
      state_q     <= StIdle;
      cand_q      <= 4'd0;
      cnt_q       <= 4'd0;
      rel_q       <= 4'd0;
      number_q    <= 32'd0;
      an_q        <= 8'hFF;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      row_meta_q  <= row_meta_d;
      row_sync_q  <= row_sync_d;
      presc_q     <= presc_d;
      col_idx_q   <= col_idx_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      number_q    <= number_d;
      an_q        <= an_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign number    = number_q;
  assign AN_ON     = an_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a physical keypad model drives the rows, a scan-level reference
// model predicts every output each cycle, and directed scenarios pin the model with literals.
module tb_keypad_entry;

  localparam int unsigned SCAN_DIV = 3;
  localparam int unsigned DEB      = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic        clear;
  logic [3:0]  col;
  logic [31:0] number;
  logic [7:0]  AN_ON;
  logic        key_valid;
  logic [3:0]  key_code;

  logic [15:0] keys;  // bit k set = hex key k held down

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .reset(reset), .row(row), .clear(clear), .col(col),
    .number(number), .AN_ON(AN_ON), .key_valid(key_valid), .key_code(key_code)
  );

  always #5 clk = ~clk;

  function automatic int krow(input int k);
    case (k)
      1, 2, 3, 10:   return 0;
      4, 5, 6, 11:   return 1;
      7, 8, 9, 12:   return 2;
      default:       return 3;
    endcase
  endfunction

  function automatic int kcol(input int k);
    case (k)
      1, 4, 7, 0:    return 0;
      2, 5, 8, 15:   return 1;
      3, 6, 9, 14:   return 2;
      default:       return 3;
    endcase
  endfunction

  // Physical keypad: a held key pulls its row low while its column is driven low
  always_comb begin
    row = 4'hF;
    for (int k = 0; k < 16; k++)
      if (keys[k] && !col[kcol(k)]) row[krow(k)] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          m_presc, m_col, run, quiet, e_digits;
  bit          held;
  logic [3:0]  run_key, e_code;
  logic [15:0] m_seen, m_h1, m_h2;
  logic [31:0] e_number;
  logic        e_valid;

  initial begin
    int n, rk;
    bit acc;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_presc = 0; m_col = 0; run = 0; quiet = 0; held = 0; run_key = 0;
        m_seen = 0; m_h1 = 0; m_h2 = 0;
        e_number = 0; e_digits = 0; e_code = 0; e_valid = 0;
      end else begin
        acc = 0;
        e_valid = 0;
        if (m_presc == SCAN_DIV) begin
          m_presc = 0;
          // rows seen at this tick were launched two edges ago
          for (int k = 0; k < 16; k++)
            if (m_h2[k] && kcol(k) == m_col) m_seen[k] = 1'b1;
          if (m_col == 3) begin
            n = $countones(m_seen);
            rk = 0;
            for (int k = 0; k < 16; k++) if (m_seen[k]) rk = k;
            if (held) begin
              quiet = (n == 0) ? quiet + 1 : 0;
              if (quiet == DEB) begin held = 0; quiet = 0; end
            end else if (run == 0) begin
              if (n == 1) begin run = 1; run_key = 4'(rk); end
            end else if (n == 1 && 4'(rk) == run_key) begin
              run++;
            end else begin
              run = 0;
            end
            if (!held && run == DEB) begin acc = 1; held = 1; run = 0; quiet = 0; end
            m_seen = 0;
          end
          m_col = (m_col + 1) % 4;
        end else begin
          m_presc++;
        end
        if (acc) begin
          e_valid = 1;
          e_code = run_key;
          if (!clear) begin
            e_number = {e_number[27:0], run_key};
            if (e_digits < 8) e_digits++;
          end
        end
        if (clear) begin e_number = 0; e_digits = 0; end
        m_h2 = m_h1;
        m_h1 = keys;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    logic [7:0] lit;
    forever begin
      @(negedge clk);
      lit = 8'((32'd1 << e_digits) - 1);
      chk("col", {28'd0, col}, {28'd0, ~(4'b0001 << m_col)});
      chk("number", number, e_number);
      chk("AN_ON", {24'd0, AN_ON}, {24'd0, ~lit});
      chk("key_valid", {31'd0, key_valid}, {31'd0, e_valid});
      chk("key_code", {28'd0, key_code}, {28'd0, e_code});
      if (key_valid) pulses++;
    end
  end

  task automatic press(input logic [15:0] m, input int on_scans, input int off_scans);
    keys = m;
    repeat (16 * on_scans) @(negedge clk);
    keys = '0;
    repeat (16 * off_scans) @(negedge clk);
  endtask

  initial begin
    int p0, first, seg;
    reset = 1'b1;
    clear = 1'b0;
    keys  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Column rotation straight out of reset
    for (int i = 0; i < 16; i++) begin
      if (i == 0)  chk("col_t0", {28'd0, col}, 32'h0000_000E);
      if (i == 4)  chk("col_t4", {28'd0, col}, 32'h0000_000D);
      if (i == 8)  chk("col_t8", {28'd0, col}, 32'h0000_000B);
      if (i == 12) chk("col_t12", {28'd0, col}, 32'h0000_0007);
      @(negedge clk);
    end
    chk("idle_pulses", pulses, 0);

    // Single '5' held for five scans: one pulse at end of the second scan
    p0 = pulses;
    first = -1;
    keys = 16'h0020;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (key_valid && first < 0) first = i;
    end
    keys = '0;
    repeat (48) @(negedge clk);
    chk("press5_latency", first, 32);
    chk("press5_pulses", pulses - p0, 1);
    chk("press5_code", {28'd0, key_code}, 32'h5);
    chk("press5_number", number, 32'h0000_0005);
    chk("press5_an", {24'd0, AN_ON}, 32'hFE);

    // Bounce: short '7', gap, short '8'
    p0 = pulses;
    press(16'h0080, 1, 2);
    press(16'h0100, 1, 3);
    chk("bounce_pulses", pulses - p0, 0);
    chk("bounce_number", number, 32'h0000_0005);

    // Overflow past eight digits
    p0 = pulses;
    for (int d = 1; d <= 9; d++) press(16'(32'd1 << d), 3, 3);
    chk("ovf_pulses", pulses - p0, 9);
    chk("ovf_number", number, 32'h2345_6789);
    chk("ovf_an", {24'd0, AN_ON}, 32'h00);

    // Two keys together are never accepted; then clear and enter 'A'
    p0 = pulses;
    press(16'h0006, 4, 3);
    chk("multi_pulses", pulses - p0, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_number", number, 32'h0);
    chk("clear_an", {24'd0, AN_ON}, 32'hFF);
    press(16'h0400, 3, 3);
    chk("keyA_number", number, 32'h0000_000A);
    chk("keyA_an", {24'd0, AN_ON}, 32'hFE);

    // Reset in the middle of a 'C' debounce
    keys = 16'h1000;
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_col", {28'd0, col}, 32'hE);
    chk("rst_number", number, 32'h0);
    chk("rst_an", {24'd0, AN_ON}, 32'hFF);
    chk("rst_valid", {31'd0, key_valid}, 32'h0);
    chk("rst_code", {28'd0, key_code}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    first = -1;
    for (int i = 1; i <= 100 && first < 0; i++) begin
      @(negedge clk);
      if (key_valid) first = i;
    end
    chk("rst_accept_window", {31'd0, (first >= 32 && first <= 48)}, 32'h1);
    chk("rst_accept_code", {28'd0, key_code}, 32'hC);
    keys = '0;
    repeat (48) @(negedge clk);

    // Randomised keying with occasional clears, checked cycle by cycle against the model
    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(0, 3))
        0:       keys = '0;
        1, 2:    keys = 16'(32'd1 << $urandom_range(0, 15));
        default: keys = 16'(32'd1 << $urandom_range(0, 15)) | 16'(32'd1 << $urandom_range(0, 15));
      endcase
      seg = $urandom_range(5, 70);
      for (int c = 0; c < seg; c++) begin
        clear = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      clear = 1'b0;
    end
    keys = '0;
    repeat (64) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
